// File: rtl/irrigacao_sequenciador_pkg.sv
// Shared definitions for the irrigation sequencer.
//   - estado_e : Moore state codes driven onto the 3-bit 'estado' output
//   - default durations in seconds (fill timeout, irrigation limit,
//     cleaning time, dosing window)
//   - BCD digit width and a helper converting a duration to 2-digit BCD
`timescale 1ns/1ps
package irrigacao_sequenciador_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [2:0] {
    ENCHENDO    = 3'b000,
    OCIOSO      = 3'b001,
    GOTEJAMENTO = 3'b010,
    ASPERSAO    = 3'b011,
    LIMPEZA     = 3'b100,
    ERRO        = 3'b101
  } estado_e;

  localparam int unsigned T_ENCHER_MAX_DEF = 60;
  localparam int unsigned T_IRRIG_MAX_DEF  = 90;
  localparam int unsigned T_LIMPEZA_DEF    = 10;
  localparam int unsigned T_AGRO_DEF       = 5;

  // Durations above 99 map to 0xFF, a pattern a saturating BCD timer never
  // holds, so the matching limit simply never fires.
  function automatic logic [2*BCD_W-1:0] to_bcd(input int unsigned v);
    logic [2*BCD_W-1:0] r;
    if (v > 99) begin
      r = '1;
    end else begin
      r[2*BCD_W-1:BCD_W] = 4'(v / 10);
      r[BCD_W-1:0]       = 4'(v % 10);
    end
    return r;
  endfunction

endpackage

// File: rtl/irrigacao_sequenciador_contador.sv
// contador_bcd_2d: 2-digit BCD counter.
//   clk_i, rst_ni  : clock, asynchronous active-low reset (value 00)
//   load_i         : load load_val_i (has priority over counting)
//   load_val_i     : {tens, units} BCD value to load
//   en_i           : count one step this cycle
//   up_i           : 1 = count up (saturates at 99), 0 = down (saturates at 00)
//   dez_o, uni_o   : tens and units digits
`timescale 1ns/1ps
module contador_bcd_2d
  import irrigacao_sequenciador_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [2*BCD_W-1:0] load_val_i,
  input  logic               en_i,
  input  logic               up_i,
  output logic [BCD_W-1:0]   dez_o,
  output logic [BCD_W-1:0]   uni_o
);

  logic [BCD_W-1:0] dez_q, dez_d;
  logic [BCD_W-1:0] uni_q, uni_d;

  always_comb begin
    dez_d = dez_q;
    uni_d = uni_q;
    if (load_i) begin
      dez_d = load_val_i[2*BCD_W-1:BCD_W];
      uni_d = load_val_i[BCD_W-1:0];
    end else if (en_i) begin
      if (up_i) begin
        if (!(dez_q == 4'd9 && uni_q == 4'd9)) begin
          if (uni_q == 4'd9) begin
            uni_d = '0;
            dez_d = dez_q + 4'd1;
          end else begin
            uni_d = uni_q + 4'd1;
          end
        end
      end else begin
        if (!(dez_q == '0 && uni_q == '0)) begin
          if (uni_q == '0) begin
            uni_d = 4'd9;
            dez_d = dez_q - 4'd1;
          end else begin
            uni_d = uni_q - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dez_q <= '0;
      uni_q <= '0;
    end else begin
      dez_q <= dez_d;
      uni_q <= uni_d;
    end
  end

  assign dez_o = dez_q;
  assign uni_o = uni_q;

endmodule

// File: rtl/irrigacao_sequenciador.sv
// irrigacao_sequenciador: timed Moore controller for the irrigation actuators.
// Owns the state register, the per-state BCD seconds timer and the dosing
// seconds counter.
//   clk, reset (async, active-low), tick_1s (1-clk pulse per second)
//   level flags   : cheio, baixo, vazio, erro_nivel
//   demand flags  : gotejamento_req, aspersao_req, agro_req
//   confirma      : operator acknowledge (used only in ERRO)
//   estado        : 3-bit state code
//   Ve, Vs, Bs, agro_out, alarme : actuator / alarm enables
//   dez, uni      : BCD timer digits for the 7-segment scan
`timescale 1ns/1ps
module irrigacao_sequenciador
  import irrigacao_sequenciador_pkg::*;
#(
  parameter int unsigned T_ENCHER_MAX = T_ENCHER_MAX_DEF,
  parameter int unsigned T_IRRIG_MAX  = T_IRRIG_MAX_DEF,
  parameter int unsigned T_LIMPEZA    = T_LIMPEZA_DEF,
  parameter int unsigned T_AGRO       = T_AGRO_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1s,
  input  logic             cheio,
  input  logic             baixo,
  input  logic             vazio,
  input  logic             erro_nivel,
  input  logic             gotejamento_req,
  input  logic             aspersao_req,
  input  logic             agro_req,
  input  logic             confirma,
  output logic [2:0]       estado,
  output logic             Ve,
  output logic             Vs,
  output logic             Bs,
  output logic             agro_out,
  output logic             alarme,
  output logic [BCD_W-1:0] dez,
  output logic [BCD_W-1:0] uni
);

  localparam logic [2*BCD_W-1:0] ENCHER_BCD  = to_bcd(T_ENCHER_MAX);
  localparam logic [2*BCD_W-1:0] IRRIG_BCD   = to_bcd(T_IRRIG_MAX);
  localparam logic [2*BCD_W-1:0] LIMPEZA_BCD = to_bcd(T_LIMPEZA);
  localparam logic [7:0]         AGRO_LIM    = 8'(T_AGRO);

  estado_e          state_q, state_d;
  logic [7:0]       agro_cnt_q, agro_cnt_d;
  logic             agro_out_q, agro_out_d;

  logic [BCD_W-1:0] dez_w, uni_w;
  logic [2*BCD_W-1:0] tempo;
  logic             mudou;
  logic             tmr_load;
  logic [2*BCD_W-1:0] tmr_load_val;
  logic             tmr_en;
  logic             tmr_up;

  assign tempo = {dez_w, uni_w};

  // Next state: level error overrides everything; unreachable codes recover
  // through ERRO.
  always_comb begin
    state_d = state_q;
    if (erro_nivel) begin
      state_d = ERRO;
    end else begin
      case (state_q)
        ENCHENDO: begin
          if (cheio)                     state_d = OCIOSO;
          else if (tempo == ENCHER_BCD)  state_d = ERRO;
        end
        OCIOSO: begin
          if (vazio || baixo)            state_d = ENCHENDO;
          else if (aspersao_req)         state_d = ASPERSAO;
          else if (gotejamento_req)      state_d = GOTEJAMENTO;
        end
        GOTEJAMENTO: begin
          if (!gotejamento_req || vazio || tempo == IRRIG_BCD)
            state_d = LIMPEZA;
        end
        ASPERSAO: begin
          if (!aspersao_req || vazio || tempo == IRRIG_BCD)
            state_d = LIMPEZA;
        end
        LIMPEZA: begin
          if (tempo == '0)               state_d = cheio ? OCIOSO : ENCHENDO;
        end
        ERRO: begin
          if (confirma)                  state_d = ENCHENDO;
        end
        default:                         state_d = ERRO;
      endcase
    end
  end

  // Timer: a state change reloads it and swallows a coincident tick.
  always_comb begin
    mudou        = (state_d != state_q);
    tmr_load     = mudou;
    tmr_load_val = (state_d == LIMPEZA) ? LIMPEZA_BCD : '0;
    tmr_up       = (state_q != LIMPEZA);
    tmr_en       = 1'b0;
    if (tick_1s && !mudou) begin
      case (state_q)
        ENCHENDO, GOTEJAMENTO, ASPERSAO, LIMPEZA: tmr_en = 1'b1;
        default:                                  tmr_en = 1'b0;
      endcase
    end
  end

  // Dosing is registered so agro_out stays a pure register output; the
  // counter advances on ticks seen while the valve is already open.
  always_comb begin
    agro_cnt_d = agro_cnt_q;
    if (state_d == ASPERSAO && state_q != ASPERSAO) begin
      agro_cnt_d = '0;
    end else if (state_q == ASPERSAO && state_d == ASPERSAO &&
                 tick_1s && agro_out_q) begin
      agro_cnt_d = agro_cnt_q + 8'd1;
    end
    agro_out_d = (state_d == ASPERSAO) && agro_req && (agro_cnt_d < AGRO_LIM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ENCHENDO;
      agro_cnt_q <= '0;
      agro_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      agro_cnt_q <= agro_cnt_d;
      agro_out_q <= agro_out_d;
    end
  end

  contador_bcd_2d u_timer (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .en_i       (tmr_en),
    .up_i       (tmr_up),
    .dez_o      (dez_w),
    .uni_o      (uni_w)
  );

  // Output decode from registered state only.
  always_comb begin
    Ve     = 1'b0;
    Vs     = 1'b0;
    Bs     = 1'b0;
    alarme = 1'b0;
    case (state_q)
      ENCHENDO:    Ve = 1'b1;
      GOTEJAMENTO: Vs = 1'b1;
      ASPERSAO:    Bs = 1'b1;
      LIMPEZA: begin
        Vs = 1'b1;
        Bs = 1'b1;
      end
      ERRO:        alarme = 1'b1;
      default: ;
    endcase
  end

  assign estado   = state_q;
  assign agro_out = agro_out_q;
  assign dez      = dez_w;
  assign uni      = uni_w;

endmodule

// File: tb/tb_irrigacao_sequenciador.sv
`timescale 1ns/1ps
module tb_irrigacao_sequenciador;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, tick_1s, cheio, baixo, vazio, erro_nivel;
  logic gotejamento_req, aspersao_req, agro_req, confirma;

  logic [2:0] estado, estado2;
  logic Ve, Vs, Bs, agro_out, alarme;
  logic Ve2, Vs2, Bs2, agro_out2, alarme2;
  logic [3:0] dez, uni, dez2, uni2;

  int n_asserts = 0;
  int n_fail    = 0;

  irrigacao_sequenciador dut (
    .clk(clk), .reset(reset), .tick_1s(tick_1s), .cheio(cheio), .baixo(baixo),
    .vazio(vazio), .erro_nivel(erro_nivel), .gotejamento_req(gotejamento_req),
    .aspersao_req(aspersao_req), .agro_req(agro_req), .confirma(confirma),
    .estado(estado), .Ve(Ve), .Vs(Vs), .Bs(Bs), .agro_out(agro_out),
    .alarme(alarme), .dez(dez), .uni(uni)
  );

  // Limits pushed beyond 99 so the saturating timer can be observed.
  irrigacao_sequenciador #(
    .T_ENCHER_MAX(100),
    .T_IRRIG_MAX (100)
  ) dut2 (
    .clk(clk), .reset(reset), .tick_1s(tick_1s), .cheio(cheio), .baixo(baixo),
    .vazio(vazio), .erro_nivel(erro_nivel), .gotejamento_req(gotejamento_req),
    .aspersao_req(aspersao_req), .agro_req(agro_req), .confirma(confirma),
    .estado(estado2), .Ve(Ve2), .Vs(Vs2), .Bs(Bs2), .agro_out(agro_out2),
    .alarme(alarme2), .dez(dez2), .uni(uni2)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1s = 1'b1;
      step();
    end
    tick_1s = 1'b0;
  endtask

  initial begin
    reset = 1'b0; tick_1s = 1'b0; cheio = 1'b0; baixo = 1'b0; vazio = 1'b0;
    erro_nivel = 1'b0; gotejamento_req = 1'b0; aspersao_req = 1'b0;
    agro_req = 1'b0; confirma = 1'b0;

    // Reset state
    step(); step();
    chk("rst_estado", 8'(estado), 8'h0);
    chk("rst_Ve", 8'(Ve), 8'h1);
    chk("rst_Vs_Bs", 8'({Vs, Bs, agro_out, alarme}), 8'h0);
    chk("rst_timer", {dez, uni}, 8'h00);
    chk("rst_estado2", 8'(estado2), 8'h0);

    reset = 1'b1;
    step();

    // Fill: 12 seconds
    ticks(12);
    chk("fill_estado", 8'(estado), 8'h0);
    chk("fill_Ve", 8'(Ve), 8'h1);
    chk("fill_timer", {dez, uni}, 8'h12);

    cheio = 1'b1;
    step();
    chk("ocioso_estado", 8'(estado), 8'h1);
    chk("ocioso_Ve", 8'(Ve), 8'h0);
    chk("ocioso_timer", {dez, uni}, 8'h00);

    // Both demands: sprinkler wins, dosing for 5 ticks
    aspersao_req = 1'b1; gotejamento_req = 1'b1; agro_req = 1'b1;
    step();
    chk("asp_estado", 8'(estado), 8'h3);
    chk("asp_Bs_Vs", 8'({Bs, Vs}), 8'h2);
    chk("asp_agro_start", 8'(agro_out), 8'h1);
    for (int i = 1; i <= 5; i++) begin
      ticks(1);
      chk($sformatf("asp_agro_t%0d", i), 8'(agro_out), (i < 5) ? 8'h1 : 8'h0);
    end
    ticks(1);
    chk("asp_agro_after", 8'(agro_out), 8'h0);
    chk("asp_timer", {dez, uni}, 8'h06);

    aspersao_req = 1'b0; gotejamento_req = 1'b0; agro_req = 1'b0;
    step();
    chk("limp_estado", 8'(estado), 8'h4);
    chk("limp_timer", {dez, uni}, 8'h10);
    chk("limp_Vs_Bs", 8'({Vs, Bs}), 8'h3);

    // Cleaning countdown with tank full
    for (int i = 1; i <= 10; i++) begin
      ticks(1);
      chk($sformatf("limp_cnt%0d", i), {dez, uni}, 8'(10 - i));
    end
    chk("limp_still", 8'(estado), 8'h4);
    step();
    chk("limp_to_ocioso", 8'(estado), 8'h1);

    // Cleaning with tank not full ends in ENCHENDO
    gotejamento_req = 1'b1;
    step();
    chk("got_estado", 8'(estado), 8'h2);
    gotejamento_req = 1'b0;
    step();
    chk("limp2_estado", 8'(estado), 8'h4);
    cheio = 1'b0;
    ticks(10);
    chk("limp2_timer", {dez, uni}, 8'h00);
    step();
    chk("limp2_to_fill", 8'(estado), 8'h0);
    chk("limp2_Ve", 8'(Ve), 8'h1);

    // Fill timeout
    ticks(60);
    chk("to_timer", {dez, uni}, 8'h60);
    chk("to_estado_pre", 8'(estado), 8'h0);
    chk("to2_no_timeout", 8'(estado2), 8'h0);
    step();
    chk("to_estado", 8'(estado), 8'h5);
    chk("to_alarme", 8'(alarme), 8'h1);
    chk("to_Ve", 8'(Ve), 8'h0);
    chk("to_timer0", {dez, uni}, 8'h00);

    confirma = 1'b1; erro_nivel = 1'b1;
    step();
    chk("erro_hold", 8'(estado), 8'h5);
    erro_nivel = 1'b0;
    step();
    chk("erro_exit", 8'(estado), 8'h0);
    chk("erro_exit2", 8'(estado2), 8'h0);
    confirma = 1'b0;

    // GOTEJAMENTO interrupted by level error on a tick
    cheio = 1'b1;
    step();
    chk("g_ocioso", 8'(estado), 8'h1);
    gotejamento_req = 1'b1;
    step();
    chk("g_estado", 8'(estado), 8'h2);
    ticks(3);
    chk("g_timer", {dez, uni}, 8'h03);
    erro_nivel = 1'b1; tick_1s = 1'b1;
    step();
    tick_1s = 1'b0;
    chk("gerr_estado", 8'(estado), 8'h5);
    chk("gerr_timer", {dez, uni}, 8'h00);
    chk("gerr_Vs", 8'(Vs), 8'h0);
    erro_nivel = 1'b0; confirma = 1'b1;
    step();
    confirma = 1'b0;
    chk("gerr_exit", 8'(estado), 8'h0);
    step();
    step();
    chk("g2_estado", 8'(estado), 8'h2);
    chk("g2_estado2", 8'(estado2), 8'h2);

    // Irrigation limit (dut) and saturation at 99 (dut2)
    ticks(90);
    chk("irr_timer", {dez, uni}, 8'h90);
    chk("irr_estado", 8'(estado), 8'h2);
    ticks(1);
    chk("irr_limp", 8'(estado), 8'h4);
    chk("irr_limp_timer", {dez, uni}, 8'h10);
    ticks(8);
    chk("sat_99", {dez2, uni2}, 8'h99);
    ticks(6);
    chk("sat_hold", {dez2, uni2}, 8'h99);
    chk("sat_estado2", 8'(estado2), 8'h2);
    chk("sat_Vs2", 8'(Vs2), 8'h1);
    chk("irr_cycle_estado", 8'(estado), 8'h2);
    chk("irr_cycle_timer", {dez, uni}, 8'h02);

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b0;
    #1;
    chk("arst_estado", 8'(estado), 8'h0);
    chk("arst_out", 8'({Ve, Vs, Bs, agro_out, alarme}), 8'h10);
    chk("arst_timer", {dez, uni}, 8'h00);
    chk("arst_estado2", 8'(estado2), 8'h0);
    chk("arst_timer2", {dez2, uni2}, 8'h00);
    chk("arst_out2", 8'({Ve2, Vs2, Bs2, agro_out2, alarme2}), 8'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
